// File: rtl/fp_mul_pkg.sv
// Shared widths, enums and exponent helpers for the FP multiplier arbiter slice.
package fp_mul_pkg;

   localparam int         FP_W    = 32;
   localparam int         RM_W    = 3;
   localparam logic [7:0] EXP_MAX = 8'hFF;

   typedef enum logic [RM_W-1:0] {RM_RNE, RM_RTZ, RM_RDN, RM_RUP, RM_RMM} rmode_e;

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} ctrl_state_e;

   typedef struct packed {
      logic [FP_W-1:0] z;
      logic            ovrf;
      logic            udrf;
   } rsp_t;

   function automatic logic is_zero_or_sub(input logic [FP_W-1:0] v);
      return v[30:23] == 8'h00;
   endfunction

   function automatic logic is_inf_nan(input logic [FP_W-1:0] v);
      return v[30:23] == EXP_MAX;
   endfunction

endpackage

// File: rtl/fp_mul_arb_ctrl_if.sv
// Requester-side request/response bundle; master = requesters, slave = arbiter controller.
interface fp_mul_arb_ctrl_if #(
   parameter int N_REQ = 2
);
   import fp_mul_pkg::*;

   logic [N_REQ-1:0]      req_valid;
   logic [N_REQ-1:0]      req_ready;
   logic [N_REQ*FP_W-1:0] req_x;
   logic [N_REQ*FP_W-1:0] req_y;
   logic [N_REQ*RM_W-1:0] req_rmode;
   logic [N_REQ-1:0]      rsp_valid;
   logic [N_REQ-1:0]      rsp_ready;
   logic [FP_W-1:0]       rsp_z;
   logic                  rsp_ovrf;
   logic                  rsp_udrf;

   modport master (
      output req_valid, req_x, req_y, req_rmode, rsp_ready,
      input  req_ready, rsp_valid, rsp_z, rsp_ovrf, rsp_udrf
   );

   modport slave (
      input  req_valid, req_x, req_y, req_rmode, rsp_ready,
      output req_ready, rsp_valid, rsp_z, rsp_ovrf, rsp_udrf
   );

endinterface

// File: rtl/fp_mul_arb_ctrl_rr_arbiter.sv
// rr_arbiter: picks the first asserted request at or above ptr, wrapping around.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module rr_arbiter #(
   parameter  int N_REQ = 2,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   logic             found;
   logic [IDX_W-1:0] idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = IDX_W'((int'(ptr) + k) % N_REQ);
         if (!found && req[idx]) begin
            found     = 1'b1;
            gnt[idx]  = 1'b1;
            gnt_idx   = idx;
         end
      end
   end

endmodule

// File: rtl/fp_mul_arb_ctrl.sv
// fp_mul_arb_ctrl: round-robin sharing of one multicycle FP multiplier core; FP_MUL_SPECIAL_BYPASS_EN enables zero/subnormal bypass.
// Latency: rsp_valid rises MC_CYCLES+1 cycles after the accept cycle (1 cycle on the bypass path).
// Backpressure: response held until the owner's rsp_ready; req_ready is low everywhere outside IDLE.
module fp_mul_arb_ctrl
   import fp_mul_pkg::*;
#(
   parameter int N_REQ     = 2,
   parameter int MC_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst,
   fp_mul_arb_ctrl_if.slave bus,
   output logic [FP_W-1:0]  core_x,
   output logic [FP_W-1:0]  core_y,
   output logic [RM_W-1:0]  core_rmode,
   input  logic [FP_W-1:0]  core_z,
   input  logic             core_ovrf,
   input  logic             core_udrf,
   output logic             busy
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;

   ctrl_state_e      state, state_nxt;
   logic [IDX_W-1:0] rr_ptr, owner, gnt_idx;
   logic [CNT_W-1:0] cnt;
   logic [N_REQ-1:0] gnt;
   rsp_t             rsp_q;
   logic [FP_W-1:0]  sel_x, sel_y;
   logic [RM_W-1:0]  sel_rmode;
   logic             accept, special;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req     (bus.req_valid),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign sel_x     = bus.req_x[FP_W*gnt_idx +: FP_W];
   assign sel_y     = bus.req_y[FP_W*gnt_idx +: FP_W];
   assign sel_rmode = bus.req_rmode[RM_W*gnt_idx +: RM_W];
   assign accept    = (state == ST_IDLE) && !rst && (|bus.req_valid);

`ifdef FP_MUL_SPECIAL_BYPASS_EN
   assign special = (is_zero_or_sub(sel_x) && !is_inf_nan(sel_y)) ||
                    (is_zero_or_sub(sel_y) && !is_inf_nan(sel_x));
`else
   assign special = 1'b0;
`endif

   // Handshake outputs are masked while rst is high so nothing is promised that reset will discard.
   assign bus.req_ready = (state == ST_IDLE && !rst) ? gnt : '0;
   assign bus.rsp_z     = rsp_q.z;
   assign bus.rsp_ovrf  = rsp_q.ovrf;
   assign bus.rsp_udrf  = rsp_q.udrf;
   assign busy          = (state != ST_IDLE);

   always_comb begin
      bus.rsp_valid = '0;
      if (state == ST_RESP && !rst) bus.rsp_valid[owner] = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = special ? ST_RESP : ST_BUSY;
         ST_BUSY: if (cnt == '0) state_nxt = ST_RESP;
         ST_RESP: if (bus.rsp_ready[owner]) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         rr_ptr     <= '0;
         owner      <= '0;
         cnt        <= '0;
         core_x     <= '0;
         core_y     <= '0;
         core_rmode <= '0;
         rsp_q      <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  owner  <= gnt_idx;
                  rr_ptr <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                  if (special) begin
                     rsp_q <= '{z: {sel_x[31] ^ sel_y[31], 31'b0}, ovrf: 1'b0, udrf: 1'b0};
                  end else begin
                     core_x     <= sel_x;
                     core_y     <= sel_y;
                     core_rmode <= sel_rmode;
                     cnt        <= CNT_W'(MC_CYCLES - 1);
                  end
               end
            end
            ST_BUSY: begin
               if (cnt != '0) cnt <= cnt - 1'b1;
               else           rsp_q <= '{z: core_z, ovrf: core_ovrf, udrf: core_udrf};
            end
            default: ;
         endcase
      end
   end

endmodule
